weight_stream_fifo: RTL and testbench
=====================================

# weight_stream_fifo

Per-stream elastic buffer placed directly downstream of a `memstream` output port, between the weight memory streamer and the consuming compute unit. It accepts the streamer's AXI-Stream words and drives the streamer's `afull` input early enough to absorb every word already in flight in the streamer's memory read pipeline. It presents a first-word-fall-through AXI-Stream master to the consumer.

## Interface
Parameters:
- `WIDTH`, 32: data width in bits.
- `DEPTH`, 32: capacity in words, including the output register. Power of two, at least 4.
- `AFULL_MARGIN`, 4: free slots remaining when `afull` asserts. Range 1..DEPTH-1. Must be at least the streamer's read-pipeline depth.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset: asynchronous, active-low.
- `s_axis_tvalid`  in  1  word valid from the streamer.
- `s_axis_tready`  out  1  high when the FIFO is not full.
- `s_axis_tdata`  in  WIDTH  word from the streamer.
- `afull`  out  1  almost-full; wired to the streamer's `afull`.
- `m_axis_tvalid`  out  1  output word valid.
- `m_axis_tready`  in  1  consumer accepts the word.
- `m_axis_tdata`  out  WIDTH  output word.
- `count`  out  $clog2(DEPTH)+1  occupancy in words (RAM plus output register).
- `ovf_sticky`  out  1  set when `s_axis_tvalid` is seen while full. Cleared only by reset.

## Operation
- Write: a write occurs when `s_axis_tvalid && s_axis_tready` at a rising edge. A write with the FIFO full does not occur; `ovf_sticky` sets and the word is not stored.
- Read: a read occurs when `m_axis_tvalid && m_axis_tready`. The output register refills from the RAM whenever it is empty, or is being read, and the RAM is non-empty.
- RAM: simple dual-port with synchronous read (one-cycle read latency). Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Count: `count` changes by +1 on a write alone, -1 on a read alone, and 0 on both in the same cycle. It never exceeds DEPTH and never goes below 0.
- Full: `s_axis_tready = (count != DEPTH)`, registered.
- Almost-full: `afull` is registered high when the next `count` is at least `DEPTH - AFULL_MARGIN`, and low otherwise. No hysteresis.
- Ordering: words leave in strict arrival order. `m_axis_tdata` is held stable while `m_axis_tvalid && !m_axis_tready`.
- Simultaneous read and write at full: the read proceeds and the write is refused (`s_axis_tready` was low). On the next cycle `s_axis_tready` rises.
- Simultaneous read and write at count 1: the new word must never overtake or duplicate the leaving word.
- Reset mid-operation: all contents are discarded, pointers and count return to 0, and `m_axis_tvalid` drops immediately (asynchronously).

## Timing
Reset values:
- `m_axis_tvalid`=0, `m_axis_tdata`=0, `count`=0, `ovf_sticky`=0.
- `s_axis_tready`=0 and `afull`=1 while `rst` is low. This stops the streamer from issuing during reset.
- After `rst` releases, `s_axis_tready`=1 and `afull`=0 from the first rising edge.

Latency and throughput:
- Empty-FIFO latency (without bypass): a word written at edge k is valid on `m_axis` after edge k+2 (RAM read plus output register).
- Throughput: one word per cycle sustained in and out simultaneously at any occupancy 1..DEPTH-1.
- `afull` and `s_axis_tready` reflect the write or read at edge k after edge k. They are never combinational from the inputs.

## Configuration
- `WEIGHT_STREAM_FIFO_BYPASS_EN` defined: when the output register is empty (or being read) and the RAM is empty, a written word loads directly into the output register. Empty-FIFO latency becomes 1 cycle (valid after edge k+1). `count` semantics are unchanged.
- Macro not defined: every word passes through the RAM, giving 2-cycle empty latency. Otherwise identical.

## Structure
- Shared package `weight_stream_pkg` holds:
  - the pointer-width and count-width localparams, derived from DEPTH;
  - the reset-value constants for `afull` and `s_axis_tready`.
- One sub-module: `wsf_ram`, a simple dual-port synchronous-read RAM with BRAM/LUTRAM inference. All control logic stays in `weight_stream_fifo`.

## Test plan
- Reset then single word: write 0xDEADBEEF with `m_axis_tready`=1. Expect `m_axis_tvalid` after edge k+2 (k+1 with bypass), data 0xDEADBEEF, `count` returns to 0.
- Fill with consumer stalled (`m_axis_tready`=0), DEPTH=32, MARGIN=4, writing 0..31:
  - `afull` rises the edge after the 28th write;
  - `s_axis_tready` falls after the 32nd write;
  - `count`=32.
- Overflow: at full, hold `s_axis_tvalid`=1 for 3 cycles. Expect `ovf_sticky`=1, `count` stays 32, and later drained data is exactly 0..31.
- Full with simultaneous read and write: at count 32, set `m_axis_tready`=1 and `s_axis_tvalid`=1. Expect the first cycle reads only (`count` 31). After that, reads and writes overlap and `count` holds at 31.
- Wrap-around stress: random `s_axis_tvalid` and `m_axis_tready` for 10,000 words with an incrementing pattern. Expect no gaps or duplicates, correct order across pointer wraps, and `count` matching a reference model every cycle.
- Mid-stream reset: assert `rst` low at count 17. Expect `m_axis_tvalid`=0 immediately and `afull`=1 during reset. After release: `count`=0, `afull`=0, and the first word out is the first word written after reset.

Source files
------------

// File: rtl/weight_stream_pkg.sv
// Shared constants for the weight stream FIFO: width helpers derived from the
// depth, and the values afull/s_axis_tready take while reset is held.
package weight_stream_pkg;

   localparam int WSF_DEPTH = 32;

   function automatic int wsf_ptr_w(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int wsf_cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   localparam int WSF_PTR_W = wsf_ptr_w(WSF_DEPTH);
   localparam int WSF_CNT_W = wsf_cnt_w(WSF_DEPTH);

   // Streamer must see "stop" while the buffer is in reset.
   localparam logic AFULL_RST  = 1'b1;
   localparam logic TREADY_RST = 1'b0;

endpackage

// File: rtl/wsf_ram.sv
// Simple dual-port RAM with registered (one-cycle) read, written so that
// synthesis maps it onto block RAM or distributed RAM.
module wsf_ram
   import weight_stream_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = WSF_DEPTH,
   parameter int ADDR_W = WSF_PTR_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/weight_stream_fifo.sv
// FWFT elastic buffer behind a memstream port; afull leaves AFULL_MARGIN slots
// for in-flight reads. Define WEIGHT_STREAM_FIFO_BYPASS_EN for 1-cycle empty latency.
module weight_stream_fifo
   import weight_stream_pkg::*;
#(
   parameter int WIDTH        = 32,
   parameter int DEPTH        = WSF_DEPTH,
   parameter int AFULL_MARGIN = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   s_axis_tvalid,
   output logic                   s_axis_tready,
   input  logic [WIDTH-1:0]       s_axis_tdata,
   output logic                   afull,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic [WIDTH-1:0]       m_axis_tdata,
   output logic [$clog2(DEPTH):0] count,
   output logic                   ovf_sticky
);

   localparam int PTR_W = wsf_ptr_w(DEPTH);
   localparam int CNT_W = wsf_cnt_w(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(DEPTH - AFULL_MARGIN);

   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             vld_p1;
   logic [WIDTH-1:0] rdata_p1, data_p1;
   logic             wr_en, rd_en, ram_has, ram_we, ram_re, ld_out, byp;
   logic [CNT_W-1:0] cnt_nxt;

   // Pointers never differ by DEPTH: the two output-side stages always hold
   // some of the occupancy once words are buffered, so equal means empty.
   always_comb begin
      wr_en   = s_axis_tvalid && s_axis_tready;
      rd_en   = m_axis_tvalid && m_axis_tready;
      ram_has = (wr_ptr != rd_ptr);
      ld_out  = vld_p1 && (!m_axis_tvalid || m_axis_tready);
      ram_re  = ram_has && (!vld_p1 || ld_out);
`ifdef WEIGHT_STREAM_FIFO_BYPASS_EN
      byp     = wr_en && !ram_has && !vld_p1 && (!m_axis_tvalid || m_axis_tready);
`else
      byp     = 1'b0;
`endif
      ram_we  = wr_en && !byp;
      cnt_nxt = count + CNT_W'(wr_en) - CNT_W'(rd_en);
   end

   wsf_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .ADDR_W(PTR_W)
   ) u_ram (
      .clk  (clk),
      .we   (ram_we),
      .waddr(wr_ptr),
      .wdata(s_axis_tdata),
      .re   (ram_re),
      .raddr(rd_ptr),
      .rdata(rdata_p1)
   );

`ifdef WEIGHT_STREAM_FIFO_BYPASS_EN
   logic             byp_sel_p1;
   logic [WIDTH-1:0] byp_data_p1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        byp_sel_p1 <= 1'b0;
      else if (byp)    byp_sel_p1 <= 1'b1;
      else if (ram_re) byp_sel_p1 <= 1'b0;
   end

   always_ff @(posedge clk) begin
      if (byp) byp_data_p1 <= s_axis_tdata;
   end

   assign data_p1 = byp_sel_p1 ? byp_data_p1 : rdata_p1;
`else
   assign data_p1 = rdata_p1;
`endif

   // ---- stage p1 (RAM read data) -> output register ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         vld_p1        <= 1'b0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         count         <= '0;
         ovf_sticky    <= 1'b0;
         s_axis_tready <= TREADY_RST;
         afull         <= AFULL_RST;
      end else begin
         if (ram_we) wr_ptr <= wr_ptr + PTR_W'(1);
         if (ram_re) rd_ptr <= rd_ptr + PTR_W'(1);

         if (ram_re || byp) vld_p1 <= 1'b1;
         else if (ld_out)   vld_p1 <= 1'b0;

         if (ld_out) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= data_p1;
         end else if (rd_en) begin
            m_axis_tvalid <= 1'b0;
         end

         count         <= cnt_nxt;
         s_axis_tready <= (cnt_nxt != FULL_CNT);
         afull         <= (cnt_nxt >= AFULL_CNT);
         if (s_axis_tvalid && (count == FULL_CNT)) ovf_sticky <= 1'b1;
      end
   end

endmodule

// File: tb/tb_weight_stream_fifo.sv
// Scoreboard bench for weight_stream_fifo: directed fill/overflow/reset cases
// plus a long randomized run against a queue-and-counter reference model.
module tb_weight_stream_fifo;

   localparam int WIDTH  = 32;
   localparam int DEPTH  = 32;
   localparam int MARGIN = 4;
   localparam int CNT_W  = $clog2(DEPTH) + 1;
`ifdef WEIGHT_STREAM_FIFO_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             s_axis_tvalid = 1'b0;
   logic             s_axis_tready;
   logic [WIDTH-1:0] s_axis_tdata = '0;
   logic             afull;
   logic             m_axis_tvalid;
   logic             m_axis_tready = 1'b0;
   logic [WIDTH-1:0] m_axis_tdata;
   logic [CNT_W-1:0] count;
   logic             ovf_sticky;

   int               n_cmp = 0;
   int               n_bad = 0;
   logic [WIDTH-1:0] exp_q[$];
   int               model_cnt = 0;
   logic             model_ovf = 1'b0;
   logic             stall_prev = 1'b0;
   logic [WIDTH-1:0] stall_data = '0;

   always #5 clk = ~clk;

   weight_stream_fifo #(
      .WIDTH       (WIDTH),
      .DEPTH       (DEPTH),
      .AFULL_MARGIN(MARGIN)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready),
      .s_axis_tdata (s_axis_tdata),
      .afull        (afull),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .m_axis_tdata (m_axis_tdata),
      .count        (count),
      .ovf_sticky   (ovf_sticky)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of accepted words and an occupancy counter that
   // follows the accept/consume rules; sampled mid-cycle on the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         exp_q.delete();
         model_cnt  = 0;
         model_ovf  = 1'b0;
         stall_prev = 1'b0;
      end else begin
         logic       wr, rd;
         logic [WIDTH-1:0] w;
         check("count", 64'(count), 64'(model_cnt));
         check("afull", 64'(afull), 64'(model_cnt >= DEPTH - MARGIN));
         check("s_tready", 64'(s_axis_tready), 64'(model_cnt != DEPTH));
         check("ovf_sticky", 64'(ovf_sticky), 64'(model_ovf));
         if (stall_prev) begin
            check("hold_valid", 64'(m_axis_tvalid), 64'(1));
            check("hold_data", 64'(m_axis_tdata), 64'(stall_data));
         end
         wr = s_axis_tvalid && (model_cnt < DEPTH);
         if (s_axis_tvalid && model_cnt == DEPTH) model_ovf = 1'b1;
         rd = m_axis_tvalid && m_axis_tready;
         if (rd) begin
            if (exp_q.size() == 0) begin
               check("spurious_out", 64'(m_axis_tdata), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               w = exp_q.pop_front();
               check("out_data", 64'(m_axis_tdata), 64'(w));
            end
            model_cnt--;
         end
         if (wr) begin
            exp_q.push_back(s_axis_tdata);
            model_cnt++;
         end
         stall_prev = m_axis_tvalid && !m_axis_tready;
         stall_data = m_axis_tdata;
      end
   end

   task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic r, output logic acc);
      s_axis_tvalid = v;
      s_axis_tdata  = d;
      m_axis_tready = r;
      @(negedge clk);
      acc = v && s_axis_tready;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      logic acc;
      int   n;
      n = 0;
      while ((count != 0 || m_axis_tvalid) && n < 200) begin
         cycle(1'b0, '0, 1'b1, acc);
         n++;
      end
      check("drained_count", 64'(count), 64'(0));
      check("drained_valid", 64'(m_axis_tvalid), 64'(0));
   endtask

   initial begin
      logic        acc;
      int          lat;
      int          w;
      int          target;
      int          cyc;
      int          vp, rp;

      // Reset values
      #1 rst = 1'b0;
      #2;
      check("rst_m_valid", 64'(m_axis_tvalid), 64'(0));
      check("rst_m_data", 64'(m_axis_tdata), 64'(0));
      check("rst_count", 64'(count), 64'(0));
      check("rst_ovf", 64'(ovf_sticky), 64'(0));
      check("rst_s_tready", 64'(s_axis_tready), 64'(0));
      check("rst_afull", 64'(afull), 64'(1));
      @(negedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_tready", 64'(s_axis_tready), 64'(1));
      check("post_rst_afull", 64'(afull), 64'(0));

      // Single word latency
      cycle(1'b1, 32'hDEAD_BEEF, 1'b1, acc);
      check("single_acc", 64'(acc), 64'(1));
      s_axis_tvalid = 1'b0;
      lat = 0;
      while (lat < 8) begin
         @(negedge clk);
         if (m_axis_tvalid) break;
         lat++;
      end
      check("single_latency", 64'(lat), 64'(LAT));
      check("single_data", 64'(m_axis_tdata), 64'(32'hDEAD_BEEF));
      @(posedge clk);
      #1;
      drain();

      // Fill with consumer stalled
      w = 0;
      cyc = 0;
      while (w < DEPTH && cyc < 200) begin
         cycle(1'b1, WIDTH'(w), 1'b0, acc);
         cyc++;
         if (acc) begin
            w++;
            check("fill_afull", 64'(afull), 64'(w >= DEPTH - MARGIN));
            check("fill_tready", 64'(s_axis_tready), 64'(w != DEPTH));
         end
      end
      check("fill_count", 64'(count), 64'(DEPTH));

      // Overflow attempts while full
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 32'hBAD0_0000 | WIDTH'(i), 1'b0, acc);
         check("ovf_refused", 64'(acc), 64'(0));
      end
      check("ovf_set", 64'(ovf_sticky), 64'(1));
      check("ovf_count", 64'(count), 64'(DEPTH));

      // Simultaneous read and write starting from full
      cycle(1'b1, WIDTH'(w), 1'b1, acc);
      check("fullrw_first_acc", 64'(acc), 64'(0));
      check("fullrw_first_count", 64'(count), 64'(DEPTH - 1));
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, WIDTH'(w), 1'b1, acc);
         if (acc) w++;
         check("fullrw_acc", 64'(acc), 64'(1));
         check("fullrw_count", 64'(count), 64'(DEPTH - 1));
      end
      drain();

      // Randomized stress with alternating fill/drain bias
      target = w + 10000;
      cyc = 0;
      while (w < target && cyc < 60000) begin
         if ((cyc / 400) % 2 == 0) begin vp = 85; rp = 40; end
         else begin vp = 40; rp = 85; end
         cycle($urandom_range(0, 99) < vp, WIDTH'(w), $urandom_range(0, 99) < rp, acc);
         if (acc) w++;
         cyc++;
      end
      check("stress_done", 64'(w >= target), 64'(1));
      drain();

      // Mid-stream reset at count 17
      w = 0;
      cyc = 0;
      while (w < 17 && cyc < 100) begin
         cycle(1'b1, 32'h5000_0000 | WIDTH'(w), 1'b0, acc);
         if (acc) w++;
         cyc++;
      end
      s_axis_tvalid = 1'b0;
      check("prereset_count", 64'(count), 64'(17));
      check("prereset_valid", 64'(m_axis_tvalid), 64'(1));
      rst = 1'b0;
      #1;
      check("midrst_valid", 64'(m_axis_tvalid), 64'(0));
      check("midrst_afull", 64'(afull), 64'(1));
      check("midrst_tready", 64'(s_axis_tready), 64'(0));
      check("midrst_count", 64'(count), 64'(0));
      cycle(1'b0, '0, 1'b0, acc);
      cycle(1'b0, '0, 1'b0, acc);
      check("midrst_afull_hold", 64'(afull), 64'(1));
      @(negedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      check("rel_count", 64'(count), 64'(0));
      check("rel_afull", 64'(afull), 64'(0));
      check("rel_tready", 64'(s_axis_tready), 64'(1));
      cycle(1'b1, 32'hA5A5_0001, 1'b1, acc);
      cycle(1'b1, 32'hA5A5_0002, 1'b1, acc);
      s_axis_tvalid = 1'b0;
      lat = 0;
      while (!m_axis_tvalid && lat < 10) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("rel_first_word", 64'(m_axis_tdata), 64'(32'hA5A5_0001));
      drain();
      check("final_queue_empty", 64'(exp_q.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
